// File: rtl/mul_shift_add_if.sv
// Operand/product handshake bundle for mul_shift_add.
// The requester drives operands and out_ready; the multiplier answers with in_ready, out_valid and product.
interface mul_shift_add_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;

   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/mul_shift_add.sv
// Sequential 32x32->64 unsigned shift-add multiplier.
// Each partial sum is formed by an external 32-bit adder, one bit per cycle.
module mul_shift_add (
   input  logic                 clk,
   input  logic                 reset,
   mul_shift_add_if.slave       bus,
   input  logic                 abort,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic [2:0]           add_op,
   input  logic [31:0]          add_res,
   input  logic [31:0]          add_cout,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] m;
   logic [63:0] p;

   // Only the top carry is meaningful for the 33-bit partial sum.
   logic unused_cout;
   assign unused_cout = ^add_cout[30:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = CALC;
         CALC: begin
            if (abort)              state_nxt = IDLE;
            else if (cnt == 6'd31)  state_nxt = DONE;
         end
         DONE: if (abort || bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m   <= '0;
         p   <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               m   <= bus.a_in;
               p   <= {32'h0, bus.b_in};
               cnt <= '0;
            end
            // Carry, sum and low half together form the 65-bit value shifted right by one.
            CALC: if (!abort) begin
               p   <= {add_cout[31], add_res, p[31:1]};
               cnt <= cnt + 6'd1;
            end
            default: ;
         endcase
      end
   end

   assign add_a         = p[63:32];
   assign add_b         = p[0] ? m : '0;
   assign add_op        = 3'b010;
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.product   = p;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: directed and random operands against a*b,
// with a model of the external adder and a per-cycle adder-port monitor.
module tb_mul_shift_add;

   logic        clk = 1'b0;
   logic        reset;
   logic        abort;
   logic [31:0] add_a, add_b, add_res, add_cout;
   logic [2:0]  add_op;
   logic        busy;

   int          total = 0;
   int          bad   = 0;
   logic        mon_en = 1'b0;
   logic [31:0] m_exp = '0;

   mul_shift_add_if bus ();

   mul_shift_add dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .abort    (abort),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_op   (add_op),
      .add_res  (add_res),
      .add_cout (add_cout),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] carries(logic [31:0] x, logic [31:0] y);
      logic [31:0] r;
      logic        c;
      c = 1'b0;
      for (int i = 0; i < 32; i++) begin
         c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
         r[i] = c;
      end
      return r;
   endfunction

   assign add_res  = add_a + add_b;
   assign add_cout = carries(add_a, add_b);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("add_op", 64'(add_op), 64'(3'b010));
         check("add_b", 64'(add_b), bus.product[0] ? 64'(m_exp) : 64'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      check("in_ready_before_accept", 64'(bus.in_ready), 64'h1);
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      bus.b_in     = b;
      tick();
      bus.in_valid = 1'b0;
      m_exp        = a;
      bus.a_in     = $urandom;
      bus.b_in     = $urandom;
   endtask

   // Returns the number of edges after the accept edge until out_valid rises (bounded).
   task automatic wait_done(output int edges);
      edges = 0;
      while (!bus.out_valid && edges < 40) begin tick(); edges++; end
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
      int e;
      accept(a, b);
      check({tag, "_busy"}, 64'(busy), 64'h1);
      wait_done(e);
      check({tag, "_latency"}, 64'(e), 64'd32);
      check({tag, "_product"}, bus.product, 64'(a) * 64'(b));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_idle"}, {62'h0, bus.in_ready, bus.out_valid}, 64'h2);
   endtask

   task automatic no_valid_window(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      check(tag, 64'(seen), 64'h0);
   endtask

   initial begin
      int e, stable;
      logic [31:0] ra, rb;
      reset         = 1'b1;
      abort         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      tick(); tick();
      check("rst_in_ready",  64'(bus.in_ready),  64'h1);
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_busy",      64'(busy),          64'h0);
      check("rst_product",   bus.product,        64'h0);
      check("rst_add_a",     64'(add_a),         64'h0);
      check("rst_add_b",     64'(add_b),         64'h0);
      check("rst_add_op",    64'(add_op),        64'h2);
      reset = 1'b0;
      tick();
      check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);
      mon_en = 1'b1;

      run_mul("m3x5",  32'd3, 32'd5);
      run_mul("mffxff", 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_mul("m0xb",  32'h0, 32'h12345678);
      run_mul("max0",  32'h12345678, 32'h0);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_mul("rand", ra, rb);
      end

      // Held result with ignored in_valid pulses.
      accept(32'd7, 32'd9);
      wait_done(e);
      check("hold_latency", 64'(e), 64'd32);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a_in     = $urandom;
         bus.b_in     = $urandom;
         tick();
         if (bus.out_valid && bus.product == 64'h3F && busy) stable++;
      end
      bus.in_valid = 1'b0;
      check("hold_stable", 64'(stable), 64'd10);
      check("hold_product", bus.product, 64'h3F);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("hold_consumed", {62'h0, bus.in_ready, busy}, 64'h2);
      tick();
      check("hold_no_restart", 64'(busy), 64'h0);

      // Asynchronous reset at cnt=10.
      accept(32'hDEADBEEF, 32'hCAFEF00D);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      m_exp = '0;
      #1;
      check("arst_idle", {61'h0, bus.in_ready, bus.out_valid, busy}, 64'h4);
      check("arst_product", bus.product, 64'h0);
      tick();
      reset = 1'b0;
      no_valid_window("arst_no_valid");
      run_mul("arst_next", 32'd2, 32'd3);

      // Abort at cnt=20.
      accept(32'hA5A5A5A5, 32'h5A5A5A5A);
      for (int i = 0; i < 20; i++) tick();
      check("abort_pre_busy", 64'(busy), 64'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {61'h0, bus.in_ready, bus.out_valid, busy}, 64'h4);
      no_valid_window("abort_no_valid");
      run_mul("abort_next", 32'd2, 32'd3);

      // Abort beats out_ready in DONE.
      accept(32'd11, 32'd13);
      wait_done(e);
      check("dabort_product", bus.product, 64'd143);
      abort         = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      abort         = 1'b0;
      bus.out_ready = 1'b0;
      check("dabort_idle", {61'h0, bus.in_ready, bus.out_valid, busy}, 64'h4);

      // Abort in IDLE does not block an accept.
      abort        = 1'b1;
      bus.in_valid = 1'b1;
      bus.a_in     = 32'd100;
      bus.b_in     = 32'd1000;
      tick();
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      m_exp        = 32'd100;
      check("iabort_busy", 64'(busy), 64'h1);
      wait_done(e);
      check("iabort_latency", 64'(e), 64'd32);
      check("iabort_product", bus.product, 64'd100000);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      run_mul("b2b_last", 32'h80000001, 32'hFFFFFFFE);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
